mem_port_arbiter: RTL and testbench

Shares the core's single-ported memory between the instruction-fetch requester and the load/store requester, which is driven by the decoder's `dmem_read`/`dmem_write`/`dmem_width` controls. Accepts one request at a time into a holding register, issues it to memory, waits for the response and routes it back to the owning requester. Data accesses have priority over fetch. An optional starvation guard bounds how long fetch can wait.

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, one transaction in flight.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_write,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_wstrb,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        owner_q, owner_d;   // 1 = load/store owns the held transaction
  logic        force_fetch;
  logic        grant_d;
  logic        grant_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt_q, starve_cnt_d;

  assign force_fetch = (starve_cnt_q == LIMIT) && if_req_valid;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant_d) begin
      if (!if_req_valid) begin
        starve_cnt_d = 4'd0;
      end else if (starve_cnt_q != LIMIT) begin
        starve_cnt_d = starve_cnt_q + 4'd1;
      end
    end else if (grant_if) begin
      starve_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 4'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  logic unused_limit;
  assign unused_limit = ^LIMIT;
  assign force_fetch  = 1'b0;
`endif

  // Readies are masked by rst_n so they read 0 while reset is held.
  assign grant_d  = rst_n && (state_q == IDLE) && d_req_valid && !force_fetch;
  assign grant_if = rst_n && (state_q == IDLE) && if_req_valid && !grant_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    wstrb_d = wstrb_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          addr_d  = d_req_addr;
          wdata_d = d_req_wdata;
          write_d = d_req_write;
          wstrb_d = d_req_wstrb;
          owner_d = 1'b1;
          state_d = ISSUE;
        end else if (grant_if) begin
          addr_d  = if_req_addr;
          wdata_d = 32'd0;
          write_d = 1'b0;
          wstrb_d = 4'b0000;
          owner_d = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (mem_rsp_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      wstrb_q <= 4'b0000;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      wstrb_q <= wstrb_d;
      owner_q <= owner_d;
    end
  end

  assign if_req_ready  = grant_if;
  assign d_req_ready   = grant_d;
  assign mem_req_valid = (state_q == ISSUE);
  assign mem_addr      = addr_q;
  assign mem_write     = write_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;
  assign busy          = (state_q != IDLE);

  // Responses outside RESP are protocol violations and never reach a requester.
  assign if_rsp_valid  = (state_q == RESP) && mem_rsp_valid && !owner_q;
  assign d_rsp_valid   = (state_q == RESP) && mem_rsp_valid && owner_q;
  assign if_rsp_data   = mem_rsp_data;
  assign d_rsp_rdata   = mem_rsp_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
// Follows MEM_ARB_STARVE_GUARD_EN to choose the expected arbitration policy.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_write, d_rsp_valid;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
  logic [3:0]  d_req_wstrb;
  logic        mem_req_valid, mem_req_ready, mem_write, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
  logic [3:0]  mem_wstrb;
  logic        busy;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_write(d_req_write), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Transaction-level model: one held transaction, whether memory accepted it, fetch wait count.
  logic        m_held, m_issued, m_owner, m_write;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  int          m_starve;
  logic        e_ir, e_dr, e_mv, e_rsp;
  logic        pend_if, pend_d;
  int          busy_cycles, rsp_pulses;
  int          dut_grants[$];

  task automatic model_reset();
    m_held = 1'b0; m_issued = 1'b0; m_owner = 1'b0; m_write = 1'b0;
    m_addr = '0; m_wdata = '0; m_wstrb = '0; m_starve = 0;
  endtask

  task automatic model_check();
    logic ff;
    ff    = GUARD && (m_starve == LIMIT) && if_req_valid;
    e_dr  = rst_n && !m_held && d_req_valid && !ff;
    e_ir  = rst_n && !m_held && if_req_valid && !e_dr;
    e_mv  = m_held && !m_issued;
    e_rsp = m_held && m_issued && mem_rsp_valid;
    check("if_req_ready", 32'(if_req_ready), 32'(e_ir));
    check("d_req_ready", 32'(d_req_ready), 32'(e_dr));
    check("mem_req_valid", 32'(mem_req_valid), 32'(e_mv));
    check("busy", 32'(busy), 32'(m_held));
    check("if_rsp_valid", 32'(if_rsp_valid), 32'(e_rsp && !m_owner));
    check("d_rsp_valid", 32'(d_rsp_valid), 32'(e_rsp && m_owner));
    if (e_mv) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_write", 32'(mem_write), 32'(m_write));
      check("mem_wdata", mem_wdata, m_wdata);
      check("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
    end
    if (e_rsp && m_owner) check("d_rsp_rdata", d_rsp_rdata, mem_rsp_data);
    if (e_rsp && !m_owner) check("if_rsp_data", if_rsp_data, mem_rsp_data);
    if (if_req_ready) dut_grants.push_back(0);
    if (d_req_ready) dut_grants.push_back(1);
    if (busy) busy_cycles++;
    if (if_rsp_valid || d_rsp_valid) rsp_pulses++;
  endtask

  task automatic model_update();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (e_rsp) begin
      m_held = 1'b0; m_issued = 1'b0;
    end else if (e_mv && mem_req_ready) begin
      m_issued = 1'b1;
    end
    if (e_dr) begin
      m_held = 1'b1; m_issued = 1'b0; m_owner = 1'b1;
      m_addr = d_req_addr; m_write = d_req_write; m_wdata = d_req_wdata; m_wstrb = d_req_wstrb;
      m_starve = if_req_valid ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      pend_d = 1'b0;
    end else if (e_ir) begin
      m_held = 1'b1; m_issued = 1'b0; m_owner = 1'b0;
      m_addr = if_req_addr; m_write = 1'b0; m_wdata = '0; m_wstrb = '0;
      m_starve = 0;
      pend_if = 1'b0;
    end
  endtask

  // Inputs are set at the falling edge; outputs are compared 1 time unit later.
  task automatic step();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drain();
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    for (int i = 0; i < 20 && m_held; i++) begin
      mem_req_ready = 1'b1;
      mem_rsp_valid = m_issued;
      step();
    end
    mem_rsp_valid = 1'b0;
    check("drain_idle", 32'(m_held), 32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    pend_if = 1'b0; pend_d = 1'b0;
    rst_n = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h40;
    d_req_valid = 1'b1; d_req_addr = 32'h80; d_req_write = 1'b1;
    d_req_wdata = 32'h1; d_req_wstrb = 4'hF;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA5A5A5A5;

    // Reset state, including readies masked while requests are present.
    #1;
    check("rst_if_ready", 32'(if_req_ready), 32'(0));
    check("rst_d_ready", 32'(d_req_ready), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'(0));
    check("rst_rsp_valid", 32'({if_rsp_valid, d_rsp_valid}), 32'(0));
    check("rst_mem_addr", mem_addr, 32'(0));
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'(0));
    @(negedge clk); @(negedge clk);
    if_req_valid = 1'b0; d_req_valid = 1'b0; mem_rsp_valid = 1'b0;
    rst_n = 1'b1;

    // Single fetch.
    if_req_valid = 1'b1; if_req_addr = 32'h100; mem_req_ready = 1'b1;
    #1 check("sf_ready", 32'(if_req_ready), 32'(1));
    step();
    if_req_valid = 1'b0;
    #1 check("sf_addr", mem_addr, 32'h100);
    check("sf_write", 32'(mem_write), 32'(0));
    step();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00500093;
    #1 check("sf_rsp_valid", 32'(if_rsp_valid), 32'(1));
    check("sf_rsp_data", if_rsp_data, 32'h00500093);
    check("sf_no_d_rsp", 32'(d_rsp_valid), 32'(0));
    step();
    mem_rsp_valid = 1'b0;
    step();

    // Simultaneous fetch and store: store first.
    if_req_valid = 1'b1; if_req_addr = 32'h104;
    d_req_valid = 1'b1; d_req_addr = 32'h2000; d_req_write = 1'b1;
    d_req_wdata = 32'hDEADBEEF; d_req_wstrb = 4'b1111;
    #1 check("sim_d_first", 32'(d_req_ready), 32'(1));
    check("sim_if_wait", 32'(if_req_ready), 32'(0));
    step();
    d_req_valid = 1'b0;
    #1 check("sim_wstrb", 32'(mem_wstrb), 32'hF);
    check("sim_wdata", mem_wdata, 32'hDEADBEEF);
    step();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0;
    #1 check("sim_d_rsp", 32'(d_rsp_valid), 32'(1));
    step();
    mem_rsp_valid = 1'b0;
    #1 check("sim_if_next", 32'(if_req_ready), 32'(1));
    step();
    drain();

    // Memory stalls: 3 cycles on ready, 2 on response.
    busy_cycles = 0; rsp_pulses = 0;
    if_req_valid = 1'b1; if_req_addr = 32'h300; mem_req_ready = 1'b0;
    step();
    if_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_addr", mem_addr, 32'h300);
      step();
    end
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    repeat (2) step();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFEF00D;
    step();
    mem_rsp_valid = 1'b0;
    step();
    check("stall_busy_cycles", 32'(busy_cycles), 32'(7));
    check("stall_rsp_pulses", 32'(rsp_pulses), 32'(1));

    // Reset while in RESP with a response arriving.
    if_req_valid = 1'b1; if_req_addr = 32'h400; mem_req_ready = 1'b1;
    step();
    if_req_valid = 1'b0;
    step();
    mem_rsp_valid = 1'b1; rst_n = 1'b0;
    #1 check("rr_if_rsp", 32'(if_rsp_valid), 32'(0));
    check("rr_d_rsp", 32'(d_rsp_valid), 32'(0));
    check("rr_busy", 32'(busy), 32'(0));
    check("rr_mem_req_valid", 32'(mem_req_valid), 32'(0));
    check("rr_mem_addr", mem_addr, 32'(0));
    model_reset();
    step();
    mem_rsp_valid = 1'b0;
    step();
    rst_n = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 32'h500;
    step();
    if_req_valid = 1'b0;
    step();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h12345678;
    #1 check("rr_after_rsp", 32'(if_rsp_valid), 32'(1));
    check("rr_after_data", if_rsp_data, 32'h12345678);
    step();
    mem_rsp_valid = 1'b0;

    // Spurious response in IDLE.
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0BADF00D;
    #1 check("sp_rsp", 32'({if_rsp_valid, d_rsp_valid}), 32'(0));
    step();
    step();
    mem_rsp_valid = 1'b0;
    #1 check("sp_busy", 32'(busy), 32'(0));
    step();

    // Continuous data with fetch pending.
    dut_grants.delete();
    if_req_valid = 1'b1; if_req_addr = 32'h600;
    d_req_valid = 1'b1; d_req_addr = 32'h700; d_req_write = 1'b0;
    d_req_wdata = 32'h0; d_req_wstrb = 4'h0;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 400 && dut_grants.size() < 20; i++) begin
      mem_rsp_valid = m_issued;
      mem_rsp_data = $urandom;
      step();
    end
    check("starve_count", 32'(dut_grants.size() >= 20), 32'(1));
    for (int i = 0; i < 20 && i < dut_grants.size(); i++) begin
      check($sformatf("starve_grant%0d", i), 32'(dut_grants[i]),
            32'((GUARD && (i % (LIMIT + 1)) == LIMIT) ? 0 : 1));
    end
    drain();

    // Randomized traffic.
    pend_if = 1'b0; pend_d = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!pend_if && ($urandom % 3 == 0)) begin
        pend_if = 1'b1; if_req_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!pend_d && ($urandom % 3 == 0)) begin
        pend_d = 1'b1; d_req_addr = $urandom; d_req_write = 1'($urandom);
        d_req_wdata = $urandom; d_req_wstrb = 4'($urandom);
      end
      if_req_valid = pend_if; d_req_valid = pend_d;
      mem_req_ready = 1'($urandom);
      mem_rsp_valid = m_issued ? 1'($urandom) : ($urandom % 8 == 0);
      mem_rsp_data = $urandom;
      step();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
